// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_FULL
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } entry_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer holding {instr, pc_plus_4} entries; flush empties it in one cycle.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     push_data,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  entry_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem port, fetch buffer, redirect handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        next_state;
  logic [31:0]   fetch_pc;
  logic [31:0]   drop_addr;
  logic          push;
  logic          pop;
  logic          drop_resp;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic          fifo_empty;
  entry_t        head;
  entry_t        push_data;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_data),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_plus_4   = fifo_empty ? 32'h0 : head.pc_plus_4;
  assign pop         = instr_valid && dec_ready && !redirect;
  assign push_data   = '{instr: imem_rdata, pc_plus_4: fetch_pc + PC_STEP};
  assign count_after = fifo_count + CW'(1) - CW'(pop);

  assign imem_req  = (state == S_REQ) || (state == S_DROP);
  // While dropping, the port keeps presenting the abandoned address until its ack returns.
  assign imem_addr = (state == S_DROP) ? drop_addr : fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    drop_resp  = 1'b0;
    case (state)
      S_IDLE: next_state = S_REQ;
      S_REQ: begin
        if (redirect) begin
          drop_resp  = imem_ack;
          next_state = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          next_state = (count_after == CW'(FIFO_DEPTH)) ? S_FULL : S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          drop_resp  = 1'b1;
          next_state = S_REQ;
        end
      end
      S_FULL: begin
        if (redirect || pop) next_state = S_REQ;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (redirect)  fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (push) fetch_pc <= fetch_pc + PC_STEP;
      if (state == S_REQ && next_state == S_DROP) drop_addr <= fetch_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (push && perf_fetched != 32'hFFFF_FFFF)      perf_fetched <= perf_fetched + 1'b1;
      if (drop_resp && perf_dropped != 32'hFFFF_FFFF) perf_dropped <= perf_dropped + 1'b1;
    end
  end
`endif

endmodule
